// File: rtl/osc_meas_sequencer.sv
// osc_meas_sequencer
// Sweeps a set of ring oscillators. For each enabled oscillator it clears
// the external counter, gates it for a programmable window, waits for the
// count to settle, captures it and hands it to a result memory through a
// request/acknowledge write port. Optional sweep tagging of the written data
// is enabled by defining OSC_SEQ_SWEEP_TAG_EN.
//
// Write handshake: wr_req_o acts as "valid" and wr_ack_i as "ready". Once
// wr_req_o rises it stays high, with wr_addr_o/wr_data_o held constant,
// until a rising clock edge samples wr_ack_i=1 while wr_req_o=1. That edge
// completes the transfer, which can happen in the very first request cycle.
// wr_ack_i has no effect in any other cycle. abort_i withdraws the request
// without a transfer, even if wr_ack_i is high on the same edge.

module osc_meas_sequencer #(
    parameter int NUM_OSC    = 10,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 27,
    parameter int SETTLE_CYC = 4,
`ifdef OSC_SEQ_SWEEP_TAG_EN
    localparam int DATA_W    = CNT_W + 8
`else
    localparam int DATA_W    = CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               continuous_i,
    input  logic [NUM_OSC-1:0] osc_mask_i,
    input  logic [WIN_W-1:0]   win_len_i,
    input  logic [CNT_W-1:0]   cnt_val_i,
    output logic [4:0]         osc_sel_o,
    output logic               osc_en_o,
    output logic               cnt_clr_o,
    output logic               wr_req_o,
    input  logic               wr_ack_i,
    output logic [4:0]         wr_addr_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2:0]         dbg_state_o
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_WRITE  = 3'd4,
        S_NEXT   = 3'd5
    } state_t;

    state_t             state;
    logic [NUM_OSC-1:0] mask_q;
    logic [WIN_W-1:0]   win_len_q;
    logic               cont_q;
    logic [WIN_W-1:0]   win_cnt;
    logic [SET_W-1:0]   set_cnt;
    logic [5:0]         next_hit;
`ifdef OSC_SEQ_SWEEP_TAG_EN
    logic [7:0]         sweep_tag;
`endif

    // Lowest set bit of a mask; only called with a non-zero mask.
    function automatic logic [4:0] lowest_idx(input logic [NUM_OSC-1:0] mask);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (mask[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above sel.
    function automatic logic [5:0] find_above(input logic [NUM_OSC-1:0] mask,
                                              input logic [4:0]         sel);
        logic [4:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) > sel)) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return {found, idx};
    endfunction

    assign next_hit    = find_above(mask_q, osc_sel_o);
    assign wr_addr_o   = osc_sel_o;
    assign dbg_state_o = state;

    // Sequencer FSM; every output except the address alias is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            win_len_q <= '0;
            cont_q    <= 1'b0;
            win_cnt   <= '0;
            set_cnt   <= '0;
            osc_sel_o <= '0;
            osc_en_o  <= 1'b0;
            cnt_clr_o <= 1'b0;
            wr_req_o  <= 1'b0;
            wr_data_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
`ifdef OSC_SEQ_SWEEP_TAG_EN
            sweep_tag <= '0;
`endif
        end else if (abort_i) begin
            // Abort beats ack and start; configuration stays latched but unused.
            state     <= S_IDLE;
            osc_en_o  <= 1'b0;
            cnt_clr_o <= 1'b0;
            wr_req_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            cnt_clr_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && (|osc_mask_i)) begin
                        mask_q    <= osc_mask_i;
                        win_len_q <= win_len_i;
                        cont_q    <= continuous_i;
                        osc_sel_o <= lowest_idx(osc_mask_i);
                        cnt_clr_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= S_CLEAR;
`ifdef OSC_SEQ_SWEEP_TAG_EN
                        sweep_tag <= '0;
`endif
                    end
                end
                S_CLEAR: begin
                    // win_cnt counts the gate cycle being entered, starting at 1.
                    osc_en_o <= 1'b1;
                    win_cnt  <= WIN_W'(1);
                    state    <= S_GATE;
                end
                S_GATE: begin
                    // A zero length ends after one cycle since 1 >= 0.
                    if (win_cnt >= win_len_q) begin
                        osc_en_o <= 1'b0;
                        set_cnt  <= SET_W'(1);
                        state    <= S_SETTLE;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (set_cnt == SET_W'(SETTLE_CYC)) begin
`ifdef OSC_SEQ_SWEEP_TAG_EN
                        wr_data_o <= {sweep_tag, cnt_val_i};
`else
                        wr_data_o <= cnt_val_i;
`endif
                        wr_req_o  <= 1'b1;
                        state     <= S_WRITE;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end
                S_WRITE: begin
                    if (wr_ack_i) begin
                        wr_req_o <= 1'b0;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (next_hit[5]) begin
                        osc_sel_o <= next_hit[4:0];
                        cnt_clr_o <= 1'b1;
                        state     <= S_CLEAR;
                    end else begin
                        done_o <= 1'b1;
`ifdef OSC_SEQ_SWEEP_TAG_EN
                        sweep_tag <= sweep_tag + 8'd1;
`endif
                        if (cont_q) begin
                            osc_sel_o <= lowest_idx(mask_q);
                            cnt_clr_o <= 1'b1;
                            state     <= S_CLEAR;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    osc_en_o <= 1'b0;
                    wr_req_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_meas_sequencer.sv
// tb_osc_meas_sequencer
// Drives sweeps into osc_meas_sequencer with a behavioural oscillator
// counter, and compares every write against a queue of expected writes.
// Honours OSC_SEQ_SWEEP_TAG_EN for the expected write data.

module tb_osc_meas_sequencer;

    localparam int NUM_OSC    = 10;
    localparam int CNT_W      = 16;
    localparam int WIN_W      = 27;
    localparam int SETTLE_CYC = 4;
`ifdef OSC_SEQ_SWEEP_TAG_EN
    localparam int DW = CNT_W + 8;
`else
    localparam int DW = CNT_W;
`endif
    // Expected entry: {addr[5], gate cycles[16], request cycles[8], data[DW]}
    localparam int EXP_W = 5 + 16 + 8 + DW;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic               abort_i;
    logic               continuous_i;
    logic [NUM_OSC-1:0] osc_mask_i;
    logic [WIN_W-1:0]   win_len_i;
    logic [CNT_W-1:0]   cnt_val_i;
    logic [4:0]         osc_sel_o;
    logic               osc_en_o;
    logic               cnt_clr_o;
    logic               wr_req_o;
    logic               wr_ack_i;
    logic [4:0]         wr_addr_o;
    logic [DW-1:0]      wr_data_o;
    logic               busy_o;
    logic               done_o;
    logic [2:0]         dbg_state_o;

    osc_meas_sequencer #(
        .NUM_OSC    (NUM_OSC),
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .continuous_i (continuous_i),
        .osc_mask_i   (osc_mask_i),
        .win_len_i    (win_len_i),
        .cnt_val_i    (cnt_val_i),
        .osc_sel_o    (osc_sel_o),
        .osc_en_o     (osc_en_o),
        .cnt_clr_o    (cnt_clr_o),
        .wr_req_o     (wr_req_o),
        .wr_ack_i     (wr_ack_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks   = 0;
    int n_pass     = 0;
    int done_cnt   = 0;
    int act_cnt    = 0;
    int en_run     = 0;
    int req_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- oscillator counter model ----------------
    // Low 12 bits: 3 ticks per gated cycle. High 4 bits: cycles since the gate
    // closed, so the captured value also pins down the capture cycle.
    logic [11:0] en_ticks = '0;
    logic [3:0]  post     = '0;
    logic        cnt_ovr  = 1'b0;

    always @(posedge clk) begin
        if (cnt_clr_o) begin
            en_ticks <= '0;
            post     <= '0;
        end else if (osc_en_o) begin
            en_ticks <= en_ticks + 12'd3;
        end else begin
            post <= post + 4'd1;
        end
    end

    assign cnt_val_i = cnt_ovr ? 16'h1234 : {post, en_ticks};

    function automatic logic [DW-1:0] exp_data(input int n_en, input int tag, input logic ovr);
        logic [CNT_W-1:0] c;
        c = ovr ? 16'h1234 : {4'(SETTLE_CYC - 1), 12'(3 * n_en)};
`ifdef OSC_SEQ_SWEEP_TAG_EN
        return {8'(tag), c};
`else
        return c;
`endif
    endfunction

    // ---------------- ack driver ----------------
    logic ack_hold  = 1'b0;
    int   ack_delay = 0;
    int   req_age   = 0;

    initial begin
        wr_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_hold) begin
                wr_ack_i = 1'b1;
            end else if (wr_req_o) begin
                wr_ack_i = (req_age == ack_delay);
                req_age++;
            end else begin
                wr_ack_i = 1'b0;
                req_age  = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (cnt_clr_o) en_run = 0;
        else if (osc_en_o) en_run++;
        if (busy_o | osc_en_o | cnt_clr_o | wr_req_o | done_o) act_cnt++;
        if (done_o) done_cnt++;
        if (wr_req_o) begin
            req_cycles++;
            check("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("wr_data", wr_data_o, e[DW-1:0]);
                if (wr_ack_i && !abort_i && !rst) begin
                    check("wr_addr", wr_addr_o, e[EXP_W-1 -: 5]);
                    check("gate_cycles", en_run, e[EXP_W-6 -: 16]);
                    check("req_cycles", req_cycles, e[DW+7 -: 8]);
                    void'(exp_q.pop_front());
                    req_cycles = 0;
                end
            end
        end else begin
            req_cycles = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_sweep(input logic [NUM_OSC-1:0] mask, input int len,
                              input int reqlen, input int tag, input logic ovr);
        int eff;
        eff = (len == 0) ? 1 : len;
        for (int i = 0; i < NUM_OSC; i++) begin
            if (mask[i]) exp_q.push_back({5'(i), 16'(eff), 8'(reqlen), exp_data(eff, tag, ovr)});
        end
    endtask

    task automatic pulse_start(input logic [NUM_OSC-1:0] mask, input int len, input logic cont);
        @(negedge clk);
        osc_mask_i   = mask;
        win_len_i    = WIN_W'(len);
        continuous_i = cont;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    // Single sweep, then check done, idle and drained queue.
    task automatic run_single(input string tag, input logic [NUM_OSC-1:0] mask,
                              input int len, input int delay, input logic hold);
        int d0;
        ack_hold  = hold;
        ack_delay = delay;
        push_sweep(mask, len, hold ? 1 : delay + 1, 0, cnt_ovr);
        d0 = done_cnt;
        pulse_start(mask, len, 1'b0);
        wait_done({tag, "_done"}, d0, 3000);
        @(negedge clk);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_qempty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int a0;
        int n;
        logic [NUM_OSC-1:0] rmask;
        rst          = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        continuous_i = 1'b0;
        osc_mask_i   = '0;
        win_len_i    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_en", osc_en_o, 0);
        check("rst_clr", cnt_clr_o, 0);
        check("rst_req", wr_req_o, 0);
        check("rst_data", wr_data_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sel", osc_sel_o, 0);
        check("rst_state", dbg_state_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two oscillators, 8-cycle window, ack held high
        run_single("sweep_0_2", 10'b0000000101, 8, 0, 1'b1);

        // Fixed count, ack after 5 waiting cycles
        cnt_ovr = 1'b1;
        run_single("ack_delay", 10'b0000010000, 3, 5, 1'b0);
        cnt_ovr = 1'b0;

        // Empty mask start is ignored
        ack_hold = 1'b0;
        a0 = act_cnt;
        pulse_start('0, 4, 1'b0);
        repeat (20) @(negedge clk);
        check("mask0_busy", busy_o, 0);
        check("mask0_activity", act_cnt - a0, 0);

        // Start while busy is ignored
        ack_delay = 1;
        push_sweep(10'b0010100001, 5, 2, 0, 1'b0);
        d0 = done_cnt;
        pulse_start(10'b0010100001, 5, 1'b0);
        repeat (10) @(negedge clk);
        pulse_start(10'b1111111111, 1, 1'b1);
        wait_done("busy_start_done", d0, 3000);
        repeat (10) @(negedge clk);
        check("busy_start_single_done", done_cnt - d0, 1);
        check("busy_start_qempty", exp_q.size(), 0);
        exp_q.delete();

        // Random sweeps
        for (int k = 0; k < 4; k++) begin
            rmask = NUM_OSC'($urandom_range(1, (1 << NUM_OSC) - 1));
            run_single("rand", rmask, $urandom_range(0, 12), $urandom_range(0, 3), 1'b0);
        end

        // Continuous, zero window, abort in WRITE with a coincident ack
        ack_hold  = 1'b0;
        ack_delay = 0;
        for (int k = 0; k < 5; k++) push_sweep(10'b1000000000, 0, 1, k, 1'b0);
        d0 = done_cnt;
        pulse_start(10'b1000000000, 0, 1'b1);
        n = 0;
        while (exp_q.size() > 1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("cont_writes_left", exp_q.size(), 1);
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (wr_req_o || n > 50) break;
        end
        check("cont_req_seen", wr_req_o, 1);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o, 0);
        check("abort_req", wr_req_o, 0);
        check("abort_en", osc_en_o, 0);
        check("abort_state", dbg_state_o, 0);
        a0 = act_cnt;
        repeat (10) @(negedge clk);
        check("abort_quiet", act_cnt - a0, 0);
        check("abort_done_cnt", done_cnt - d0, 4);
        check("abort_no_xfer", exp_q.size(), 1);
        exp_q.delete();

        // Reset in GATE, then a fresh sweep
        ack_hold = 1'b1;
        push_sweep(10'b0000001100, 20, 1, 0, 1'b0);
        pulse_start(10'b0000001100, 20, 1'b0);
        n = 0;
        while (!osc_en_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gate_seen", osc_en_o, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_en", osc_en_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_clr", cnt_clr_o, 0);
        check("midrst_req", wr_req_o, 0);
        check("midrst_sel", osc_sel_o, 0);
        check("midrst_data", wr_data_o, 0);
        check("midrst_done", done_o, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_single("post_rst", 10'b0000000110, 2, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
